// File: rtl/booth_radix8_encoder.sv
// -----------------------------------------------------------------------------
// booth_radix8_encoder
//
// Radix-8 Booth recoder and partial-product generator. It is the front end of an
// unsigned multiplier. The multiplier operand B is recoded into NUM_TERMS signed
// digits in {-4..+4}. Each digit selects a multiple of the multiplicand M.
// All partial products are packed into one registered bus. A downstream
// compressor/adder tree forms the product as sum_i sext(pp_i) << (3*i).
//
// Latency is one clock. New operands are accepted every cycle and there is no
// handshake.
//
// Optional feature (compile-time macro):
//   BOOTH_DIGIT_OUT_EN  when defined, adds output `digits`. It carries each
//                       recoded digit as 4-bit two's complement and is
//                       registered on the same edge as `result`.
//
// Ports:
//   clk           in   1                clock, rising edge
//   rst_n         in   1                asynchronous active-low reset
//   multiplicand  in   DATA_WIDTH       unsigned operand M
//   multiplier    in   DATA_WIDTH       unsigned operand B (recoded)
//   result        out  CAPACITY_RESULT  packed partial products, term 0 in LSBs
//   digits        out  4*NUM_TERMS      [BOOTH_DIGIT_OUT_EN] digit per term, term 0 in LSBs
// -----------------------------------------------------------------------------
module booth_radix8_encoder #(
  parameter  int DATA_WIDTH      = 6,
  localparam int NUM_TERMS       = (DATA_WIDTH + 5) / 3,
  localparam int PP_WIDTH        = 2 * DATA_WIDTH - 1,
  localparam int CAPACITY_RESULT = PP_WIDTH * NUM_TERMS
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [DATA_WIDTH-1:0]      multiplicand,
  input  logic [DATA_WIDTH-1:0]      multiplier,
  output logic [CAPACITY_RESULT-1:0] result
`ifdef BOOTH_DIGIT_OUT_EN
  ,
  output logic [4*NUM_TERMS-1:0]     digits
`endif
);

  // The multiplier is zero-extended to 3*NUM_TERMS bits. A zero is appended
  // below bit 0 and serves as b[-1]. The extension is always at least 3 bits,
  // so the top digit can never be negative.
  localparam int EXT_WIDTH = 3 * NUM_TERMS;
  localparam int EXT_PAD   = EXT_WIDTH - DATA_WIDTH;

  logic [EXT_WIDTH:0] b_ext;
  assign b_ext = {{EXT_PAD{1'b0}}, multiplier, 1'b0};

  // Odd multiples of M are precomputed once and shared by every term.
  // 3M is the only multiple that needs an adder.
  logic [PP_WIDTH-1:0] m1, m2, m3, m4;
  assign m1 = {{(PP_WIDTH - DATA_WIDTH){1'b0}}, multiplicand};
  assign m2 = m1 << 1;
  assign m4 = m1 << 2;
  assign m3 = m1 + m2;

  // Combinational partial product per term. The name is kept stable so that
  // debug probes can reach it hierarchically.
  logic [PP_WIDTH-1:0] ir_result [NUM_TERMS];
  logic [3:0]          digit_w   [NUM_TERMS];

  for (genvar g = 0; g < NUM_TERMS; g++) begin : g_term
    logic [3:0]          win;      // {b[3g+2], b[3g+1], b[3g], b[3g-1]}
    logic [3:0]          dig_abs;
    logic [PP_WIDTH-1:0] mag;

    assign win = b_ext[3*g +: 4];

    // d = -4*b2 + 2*b1 + b0 + b-1. The signed 3-bit value {b2,b1,b0} equals
    // -4*b2 + 2*b1 + b0, so only b-1 has to be added. The range -4..+4 fits
    // in 4 bits without overflow.
    assign digit_w[g] = {win[3], win[3], win[2], win[1]} + {3'b000, win[0]};
    assign dig_abs    = digit_w[g][3] ? -digit_w[g] : digit_w[g];

    // NOTE: every always_comb assigns its outputs a default value first, so
    // that no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
      mag = '0;
      case (dig_abs)
        4'd1:    mag = m1;
        4'd2:    mag = m2;
        4'd3:    mag = m3;
        4'd4:    mag = m4;
        default: mag = '0;
      endcase
    end

    // Digit 0 gives mag == 0. Negating zero gives zero, so the output never
    // carries a "-0" pattern.
    assign ir_result[g] = digit_w[g][3] ? -mag : mag;
  end

  // Pack the terms without shifting them. Term i occupies its own PP_WIDTH slice.
  logic [CAPACITY_RESULT-1:0] result_d, result_q;

  always_comb begin
    result_d = '0;
    for (int i = 0; i < NUM_TERMS; i++) begin
      result_d[i*PP_WIDTH +: PP_WIDTH] = ir_result[i];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
    end else begin
      result_q <= result_d;
    end
  end

  assign result = result_q;

`ifdef BOOTH_DIGIT_OUT_EN
  logic [4*NUM_TERMS-1:0] digits_d, digits_q;

  always_comb begin
    digits_d = '0;
    for (int i = 0; i < NUM_TERMS; i++) begin
      digits_d[4*i +: 4] = digit_w[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits_q <= '0;
    end else begin
      digits_q <= digits_d;
    end
  end

  assign digits = digits_q;
`endif

endmodule

// File: tb/tb_booth_radix8_encoder.sv
// -----------------------------------------------------------------------------
// tb_booth_radix8_encoder
//
// Scoreboard bench for booth_radix8_encoder at DATA_WIDTH = 6.
//
// The driver applies one operand pair per negedge and pushes the expected
// packed result onto a queue. For directed vectors the expected value is a
// hand-computed constant. For swept vectors it comes from a table-driven
// reference model.
//
// The monitor samples 1 time unit after every posedge while reset is high. It
// pops one entry per loaded pair and compares the packed result. It also checks
// that sum sext(pp_i) << 3i equals M*B modulo 2^12.
// -----------------------------------------------------------------------------
module tb_booth_radix8_encoder;

  localparam int DW  = 6;
  localparam int NT  = 3;
  localparam int PPW = 11;
  localparam int CAP = 33;

  typedef struct {
    logic [DW-1:0]   m;
    logic [DW-1:0]   b;
    logic [CAP-1:0]  res;
    logic [4*NT-1:0] dig;
  } exp_t;

  logic           clk;
  logic           rst_n;
  logic [DW-1:0]  multiplicand;
  logic [DW-1:0]  multiplier;
  logic [CAP-1:0] result;
`ifdef BOOTH_DIGIT_OUT_EN
  logic [4*NT-1:0] digits;
`endif

  booth_radix8_encoder dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .result       (result)
`ifdef BOOTH_DIGIT_OUT_EN
    ,
    .digits       (digits)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference recoding written as the lookup table on {b2,b1,b0,b-1}.
  function automatic int tbl_digit(input logic [3:0] w);
    case (w)
      4'b0000, 4'b1111: return 0;
      4'b0001, 4'b0010: return 1;
      4'b0011, 4'b0100: return 2;
      4'b0101, 4'b0110: return 3;
      4'b0111:          return 4;
      4'b1000:          return -4;
      4'b1001, 4'b1010: return -3;
      4'b1011, 4'b1100: return -2;
      default:          return -1;
    endcase
  endfunction

  function automatic logic [CAP-1:0] model_result(input logic [DW-1:0] m, input logic [DW-1:0] b);
    logic [3*NT:0]  be;
    logic [CAP-1:0] r;
    int             p;
    be = {3'b000, b, 1'b0};
    r  = '0;
    for (int i = 0; i < NT; i++) begin
      p = tbl_digit(be[3*i +: 4]) * int'(m);
      r[i*PPW +: PPW] = p[PPW-1:0];
    end
    return r;
  endfunction

  function automatic logic [4*NT-1:0] model_digits(input logic [DW-1:0] b);
    logic [3*NT:0]   be;
    logic [4*NT-1:0] r;
    int              d;
    be = {3'b000, b, 1'b0};
    r  = '0;
    for (int i = 0; i < NT; i++) begin
      d = tbl_digit(be[3*i +: 4]);
      r[4*i +: 4] = d[3:0];
    end
    return r;
  endfunction

  // Drive operands now and queue the expected outcome of the next posedge.
  task automatic drive(input logic [DW-1:0] m, input logic [DW-1:0] b, input logic [CAP-1:0] exp_res);
    exp_t e;
    multiplicand = m;
    multiplier   = b;
    e.m   = m;
    e.b   = b;
    e.res = exp_res;
    e.dig = model_digits(b);
    sb.push_back(e);
  endtask

  task automatic apply(input logic [DW-1:0] m, input logic [DW-1:0] b, input logic [CAP-1:0] exp_res);
    @(negedge clk);
    drive(m, b, exp_res);
  endtask

  // Monitor: one pop per loaded operand pair, checked after the edge.
  initial begin
    exp_t           e;
    longint         acc;
    logic [11:0]    prod;
    logic [11:0]    acc12;
    logic signed [PPW-1:0] pp;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && sb.size() > 0) begin
        e = sb.pop_front();
        check($sformatf("result M=%0d B=%0d", e.m, e.b), 64'(result), 64'(e.res));
        acc = 0;
        for (int i = 0; i < NT; i++) begin
          pp  = result[i*PPW +: PPW];
          acc = acc + (longint'(pp) <<< (3*i));
        end
        acc12 = acc[11:0];
        prod  = 12'(e.m) * 12'(e.b);
        check($sformatf("sum M=%0d B=%0d", e.m, e.b), 64'(acc12), 64'(prod));
`ifdef BOOTH_DIGIT_OUT_EN
        check($sformatf("digits B=%0d", e.b), 64'(digits), 64'(e.dig));
`endif
      end
    end
  end

  initial begin
    logic [DW-1:0] rm, rb;
    rst_n        = 1'b0;
    multiplicand = 6'd53;
    multiplier   = 6'd27;

    // Reset holds result at zero even across clock edges.
    repeat (2) @(posedge clk);
    #1;
    check("reset result", 64'(result), 64'd0);

    // Release reset and load M=53, B=27 on the first edge: digits {0,+3,+3}.
    @(negedge clk);
    rst_n = 1'b1;
    drive(6'd53, 6'd27, {11'd0,  11'd159,  11'd159});
    // Hand-computed vectors, applied back to back with no idle cycles.
    apply(6'd53, 6'd63, {11'd53, 11'd0,    11'd1995});  // {+1,0,-1}
    apply(6'd63, 6'd4,  {11'd0,  11'd63,   11'd1796});  // -4, +1
    apply(6'd0,  6'd45, {11'd0,  11'd0,    11'd0});
    apply(6'd63, 6'd0,  {11'd0,  11'd0,    11'd0});
    apply(6'd63, 6'd63, {11'd63, 11'd0,    11'd1985});
    apply(6'd1,  6'd1,  {11'd0,  11'd0,    11'd1});
    apply(6'd10, 6'd7,  {11'd0,  11'd10,   11'd2038});
    apply(6'd63, 6'd36, {11'd63, 11'd1859, 11'd1796});  // -4, -3, +1
    apply(6'd53, 6'd27, {11'd0,  11'd159,  11'd159});

    // Sweep against the table-driven model.
    for (int i = 0; i < 40; i++) begin
      rm = 6'($urandom_range(0, 63));
      rb = 6'($urandom_range(0, 63));
      apply(rm, rb, model_result(rm, rb));
    end

    // Let the monitor drain the queue, then assert reset away from any edge.
    repeat (3) @(posedge clk);
    check("queue drained before reset", 64'(sb.size()), 64'd0);
    #3;
    rst_n = 1'b0;
    #1;
    check("async reset result", 64'(result), 64'd0);
    @(posedge clk);
    #1;
    check("reset held across edge", 64'(result), 64'd0);

    // The first edge after release loads the current operands normally.
    @(negedge clk);
    rst_n = 1'b1;
    drive(6'd63, 6'd36, {11'd63, 11'd1859, 11'd1796});
    apply(6'd53, 6'd63, {11'd53, 11'd0,    11'd1995});

    repeat (4) @(posedge clk);
    #2;
    check("queue drained at end", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
